qpu_exu_evtq: RTL



---
 rtl/qpu_exu_evtq.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/qpu_exu_evtq.sv
// qpu_exu_evtq: timed event queue behind the QPU execution ALU.
// Each event is buffered with an absolute timestamp. The event is released on
// evt_o_* one cycle after the free-running timer reaches that timestamp.
// Optional feature macro: QPU_EVTQ_LATE_CHK_EN enables sticky late-pop detection.
module qpu_exu_evtq #(
  parameter int TW    = 32,
  parameter int EW    = 32,
  parameter int EN    = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       twbck_i_valid,
  output logic                       twbck_i_ready,
  input  logic [TW-1:0]              twbck_i_data,
  input  logic                       ewbck_i_valid,
  output logic                       ewbck_i_ready,
  input  logic [EW-1:0]              ewbck_i_data,
  input  logic [EN-1:0]              ewbck_i_oprand,
  input  logic                       tq_start,
  input  logic                       tq_clr,
  output logic                       evt_o_valid,
  output logic [EW-1:0]              evt_o_data,
  output logic [EN-1:0]              evt_o_oprand,
  output logic [TW-1:0]              evt_o_time,
  output logic [TW-1:0]              tq_timer,
  output logic [TW-1:0]              tq_cur_time,
  output logic [$clog2(DEPTH):0]     tq_count,
  output logic                       tq_empty,
  output logic                       tq_full,
  output logic                       tq_late_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [TW-1:0]   timer_r, timer_nxt_s;
  logic [TW-1:0]   cur_time_r;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r, count_nxt_s;
  logic            empty_r, full_r;
  logic [TW-1:0]   ts_mem_r   [DEPTH];
  logic [EW-1:0]   data_mem_r [DEPTH];
  logic [EN-1:0]   opr_mem_r  [DEPTH];
  logic            push_s, pop_s, active_s;
  logic [TW-1:0]   head_ts_s, push_ts_s;
  logic            evt_valid_r;
  logic [EW-1:0]   evt_data_r;
  logic [EN-1:0]   evt_opr_r;
  logic [TW-1:0]   evt_time_r;

  assign active_s  = (state_r == ST_RUN) || (state_r == ST_HALT);
  assign head_ts_s = ts_mem_r[rd_ptr_r];
  // A timing point written in the same cycle as a push applies to that push.
  assign push_ts_s = twbck_i_valid ? twbck_i_data : cur_time_r;
  // A flush in the same cycle discards any push or pop.
  assign push_s    = ewbck_i_valid & ~full_r & ~tq_clr;
  assign pop_s     = active_s & ~empty_r & (head_ts_s <= timer_r) & ~tq_clr;

  // FSM state register and system timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      timer_r <= {TW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      timer_r <= timer_nxt_s;
    end
  end

  // Next-state and timer update: IDLE holds 0, RUN counts, HALT freezes at all-ones
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    if (tq_clr) begin
      state_nxt_s = ST_IDLE;
      timer_nxt_s = {TW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          timer_nxt_s = {TW{1'b0}};
          if (tq_start) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (timer_r == {TW{1'b1}}) begin
            state_nxt_s = ST_HALT;
          end else begin
            timer_nxt_s = timer_r + TW'(1);
          end
        end
        ST_HALT: begin
          state_nxt_s = ST_HALT;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          timer_nxt_s = {TW{1'b0}};
        end
      endcase
    end
  end

  // Occupancy bookkeeping for the next edge
  always_comb begin
    count_nxt_s = count_r;
    if (tq_clr) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Timing point, pointers and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_time_r <= {TW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
    end else begin
      if (tq_clr) begin
        cur_time_r <= {TW{1'b0}};
        wr_ptr_r   <= {AW{1'b0}};
        rd_ptr_r   <= {AW{1'b0}};
      end else begin
        if (twbck_i_valid) cur_time_r <= twbck_i_data;
        if (push_s)        wr_ptr_r   <= wr_ptr_r + AW'(1);
        if (pop_s)         rd_ptr_r   <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == {CW{1'b0}});
      full_r  <= (count_nxt_s == CW'(DEPTH));
    end
  end

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr
  always_ff @(posedge clk) begin
    if (push_s) begin
      ts_mem_r[wr_ptr_r]   <= push_ts_s;
      data_mem_r[wr_ptr_r] <= ewbck_i_data;
      opr_mem_r[wr_ptr_r]  <= ewbck_i_oprand;
    end
  end

  // Registered emission port; payload holds its last value between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_r <= 1'b0;
      evt_data_r  <= {EW{1'b0}};
      evt_opr_r   <= {EN{1'b0}};
      evt_time_r  <= {TW{1'b0}};
    end else begin
      evt_valid_r <= pop_s;
      if (pop_s) begin
        evt_data_r <= data_mem_r[rd_ptr_r];
        evt_opr_r  <= opr_mem_r[rd_ptr_r];
        evt_time_r <= head_ts_s;
      end
    end
  end

`ifdef QPU_EVTQ_LATE_CHK_EN
  logic late_err_r;

  // Sticky late flag: set by any pop whose timestamp already passed; a flush does not clear it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      late_err_r <= 1'b0;
    end else if (pop_s && (head_ts_s < timer_r)) begin
      late_err_r <= 1'b1;
    end
  end

  assign tq_late_err = late_err_r;
`else
  assign tq_late_err = 1'b0;
`endif

  assign twbck_i_ready = 1'b1;
  assign ewbck_i_ready = ~full_r;
  assign evt_o_valid   = evt_valid_r;
  assign evt_o_data    = evt_data_r;
  assign evt_o_oprand  = evt_opr_r;
  assign evt_o_time    = evt_time_r;
  assign tq_timer      = timer_r;
  assign tq_cur_time   = cur_time_r;
  assign tq_count      = count_r;
  assign tq_empty      = empty_r;
  assign tq_full       = full_r;

endmodule
